// File: rtl/rrf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rrf_alloc_ctrl
// Purpose  : Allocation controller for rename register file (RRF) entries.
//            Grants up to two rrftags per cycle to dispatch in circular
//            order, reclaims up to two entries per cycle on ROB commit, and
//            discards all speculative allocations on a branch mispredict.
// Ports    :
//   clk_i, reset_n_i         clock (rising edge), async active-low reset
//   req1_i, req2_i           dispatch slots needing a destination rrftag
//   dp_valid_i               dispatch group valid
//   allocatable_o            enough free entries for the current request
//   alloc_fire_o             allocation performed this cycle
//   rrftag1_o, rrftag2_o     tags granted to slot 1 / slot 2
//   rrfptr_o, nextrrfcyc_o   next tag to allocate and its wrap-parity bit
//   com_num_i                entries retired by the ROB this cycle (0..2)
//   comptr_o                 oldest uncommitted tag
//   prmiss_i                 mispredict flush
//   used_cnt_o               entries currently allocated (0..RRF_NUM)
// Revision : 1.0 - initial release
// ============================================================================
module rrf_alloc_ctrl #(
  parameter int RRF_SEL = 6,
  parameter int RRF_NUM = 64   // must equal 2**RRF_SEL
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               req1_i,
  input  logic               req2_i,
  input  logic               dp_valid_i,
  output logic               allocatable_o,
  output logic               alloc_fire_o,
  output logic [RRF_SEL-1:0] rrftag1_o,
  output logic [RRF_SEL-1:0] rrftag2_o,
  output logic [RRF_SEL-1:0] rrfptr_o,
  output logic               nextrrfcyc_o,
  input  logic [1:0]         com_num_i,
  output logic [RRF_SEL-1:0] comptr_o,
  input  logic               prmiss_i,
  output logic [RRF_SEL:0]   used_cnt_o
);

  localparam logic [RRF_SEL:0] c_RRF_NUM = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] r_rrfptr;
  logic [RRF_SEL-1:0] r_comptr;
  logic               r_nextrrfcyc;
  logic               r_comcyc;
  logic [RRF_SEL:0]   r_used_cnt;

  logic [1:0]         w_nreq;
  logic [RRF_SEL:0]   w_free;
  logic               w_allocatable;
  logic               w_fire;
  logic [RRF_SEL:0]   w_ptr_sum;   // carry bit marks a wrap of rrfptr
  logic [RRF_SEL:0]   w_com_sum;   // carry bit marks a wrap of comptr
  logic [1:0]         w_add;
  logic [RRF_SEL+1:0] w_used_sum;
  logic [RRF_SEL+1:0] w_com_ext;
  logic [RRF_SEL:0]   w_used_next;

  assign w_nreq        = {1'b0, req1_i} + {1'b0, req2_i};
  // Same-cycle frees are deliberately not credited: the stall is conservative
  // and does not depend on the commit path timing.
  assign w_free        = c_RRF_NUM - r_used_cnt;
  assign w_allocatable = (w_free >= (RRF_SEL+1)'(w_nreq));
  assign w_fire        = dp_valid_i & w_allocatable & ~prmiss_i & (w_nreq != 2'd0);

  // Because RRF_NUM is a power of two, the carry out of the tag-width add is
  // exactly the "crossed RRF_NUM" condition.
  assign w_ptr_sum = {1'b0, r_rrfptr} + (RRF_SEL+1)'(w_nreq);
  assign w_com_sum = {1'b0, r_comptr} + (RRF_SEL+1)'(com_num_i);

  assign w_add      = w_fire ? w_nreq : 2'd0;
  assign w_used_sum = {1'b0, r_used_cnt} + (RRF_SEL+2)'(w_add);
  assign w_com_ext  = (RRF_SEL+2)'(com_num_i);

  // Over-commit is illegal upstream; clamp at zero rather than wrapping.
  always_comb begin
    w_used_next = '0;
    if (w_used_sum >= w_com_ext) begin
      w_used_next = RRF_SEL'(0) + (RRF_SEL+1)'(w_used_sum - w_com_ext);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rrfptr     <= '0;
      r_comptr     <= '0;
      r_nextrrfcyc <= 1'b0;
      r_comcyc     <= 1'b0;
      r_used_cnt   <= '0;
    end else begin
      // Commits apply regardless of flush.
      r_comptr <= w_com_sum[RRF_SEL-1:0];
      r_comcyc <= r_comcyc ^ w_com_sum[RRF_SEL];
      if (prmiss_i) begin
        // Roll the allocation pointer back to the post-commit oldest entry;
        // everything younger is speculative and is dropped.
        r_rrfptr     <= w_com_sum[RRF_SEL-1:0];
        r_nextrrfcyc <= r_comcyc ^ w_com_sum[RRF_SEL];
        r_used_cnt   <= '0;
      end else begin
        if (w_fire) begin
          r_rrfptr     <= w_ptr_sum[RRF_SEL-1:0];
          r_nextrrfcyc <= r_nextrrfcyc ^ w_ptr_sum[RRF_SEL];
        end
        r_used_cnt <= w_used_next;
      end
    end
  end

  assign allocatable_o = w_allocatable;
  assign alloc_fire_o  = w_fire;
  assign rrftag1_o     = r_rrfptr;
  // Slot 2 takes the second tag only when slot 1 also consumed one.
  assign rrftag2_o     = req1_i ? (r_rrfptr + RRF_SEL'(1)) : r_rrfptr;
  assign rrfptr_o      = r_rrfptr;
  assign nextrrfcyc_o  = r_nextrrfcyc;
  assign comptr_o      = r_comptr;
  assign used_cnt_o    = r_used_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rrf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrf_alloc_ctrl
// Purpose  : Directed self-checking bench for rrf_alloc_ctrl with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrf_alloc_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       req1_i, req2_i, dp_valid_i, prmiss_i;
  logic [1:0] com_num_i;
  logic       allocatable_o, alloc_fire_o, nextrrfcyc_o;
  logic [5:0] rrftag1_o, rrftag2_o, rrfptr_o, comptr_o;
  logic [6:0] used_cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  rrf_alloc_ctrl #(.RRF_SEL(6), .RRF_NUM(64)) u_dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req1_i        (req1_i),
    .req2_i        (req2_i),
    .dp_valid_i    (dp_valid_i),
    .allocatable_o (allocatable_o),
    .alloc_fire_o  (alloc_fire_o),
    .rrftag1_o     (rrftag1_o),
    .rrftag2_o     (rrftag2_o),
    .rrfptr_o      (rrfptr_o),
    .nextrrfcyc_o  (nextrrfcyc_o),
    .com_num_i     (com_num_i),
    .comptr_o      (comptr_o),
    .prmiss_i      (prmiss_i),
    .used_cnt_o    (used_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Committing more entries than are allocated is an illegal stimulus.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ({5'd0, com_num_i} <= used_cnt_o)
        else $error("illegal over-commit: com_num=%0d used=%0d", com_num_i, used_cnt_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r1, input logic r2,
                       input logic [1:0] k, input logic pm);
    dp_valid_i = v;
    req1_i     = r1;
    req2_i     = r2;
    com_num_i  = k;
    prmiss_i   = pm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    drive(0, 0, 0, 2'd0, 0);
    #12;
    check("rst_rrfptr",  rrfptr_o,      0);
    check("rst_comptr",  comptr_o,      0);
    check("rst_used",    used_cnt_o,    0);
    check("rst_cyc",     nextrrfcyc_o,  0);
    check("rst_alloc",   allocatable_o, 1);
    reset_n_i = 1'b1;
    tick();

    // Dual allocation straight after reset
    drive(1, 1, 1, 2'd0, 0);
    check("dual_tag1", rrftag1_o,    0);
    check("dual_tag2", rrftag2_o,    1);
    check("dual_fire", alloc_fire_o, 1);
    tick();
    check("dual_ptr",  rrfptr_o,   2);
    check("dual_used", used_cnt_o, 2);

    // Three singles to reach rrfptr=5, then slot-2-only request
    drive(1, 1, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("pre5_ptr", rrfptr_o, 5);
    drive(1, 0, 1, 2'd0, 0);
    check("s2_tag2", rrftag2_o,    5);
    check("s2_fire", alloc_fire_o, 1);
    tick();
    check("s2_ptr",  rrfptr_o,   6);
    check("s2_used", used_cnt_o, 6);

    // Fill to 63: 28 duals then one single
    drive(1, 1, 1, 2'd0, 0);
    for (int i = 0; i < 28; i++) tick();
    drive(1, 1, 0, 2'd0, 0);
    tick();
    check("fill_used", used_cnt_o, 63);
    check("fill_ptr",  rrfptr_o,   63);
    drive(1, 1, 1, 2'd0, 0);
    check("f63_dual_alloc", allocatable_o, 0);
    check("f63_dual_fire",  alloc_fire_o,  0);
    tick();
    check("f63_hold_used", used_cnt_o, 63);
    check("f63_hold_ptr",  rrfptr_o,   63);
    drive(1, 1, 0, 2'd0, 0);
    check("f63_single_fire", alloc_fire_o, 1);
    check("f63_single_tag",  rrftag1_o,    63);
    tick();
    check("full_used", used_cnt_o,   64);
    check("full_ptr",  rrfptr_o,     0);
    check("full_cyc",  nextrrfcyc_o, 1);
    check("full_stall", allocatable_o, 0);
    check("full_fire",  alloc_fire_o,  0);
    drive(1, 0, 1, 2'd0, 0);
    check("full_stall2", allocatable_o, 0);

    // Drain 54 entries by commit only
    drive(0, 0, 0, 2'd2, 0);
    for (int i = 0; i < 27; i++) tick();
    check("drain_used",   used_cnt_o, 10);
    check("drain_comptr", comptr_o,   54);

    // Dual allocate with dual commit at used=10
    drive(1, 1, 1, 2'd2, 0);
    check("ac_tag1", rrftag1_o, 0);
    check("ac_tag2", rrftag2_o, 1);
    tick();
    check("ac_used",   used_cnt_o, 10);
    check("ac_ptr",    rrfptr_o,   2);
    check("ac_comptr", comptr_o,   56);

    // Advance both pointers to rrfptr=63 while holding used=10
    for (int i = 0; i < 30; i++) tick();
    drive(1, 1, 0, 2'd1, 0);
    tick();
    check("adv_ptr",    rrfptr_o,   63);
    check("adv_comptr", comptr_o,   53);
    check("adv_used",   used_cnt_o, 10);
    check("adv_cyc",    nextrrfcyc_o, 1);

    // Wrap: dual request at 63
    drive(1, 1, 1, 2'd0, 0);
    check("wrap_tag1", rrftag1_o, 63);
    check("wrap_tag2", rrftag2_o, 0);
    tick();
    check("wrap_ptr",  rrfptr_o,     1);
    check("wrap_cyc",  nextrrfcyc_o, 0);
    check("wrap_used", used_cnt_o,   12);

    // Async reset in the middle of a burst, away from the clock edge
    drive(1, 1, 1, 2'd0, 0);
    tick();
    #1;
    reset_n_i = 1'b0;
    #1;
    check("arst_ptr",    rrfptr_o,     0);
    check("arst_comptr", comptr_o,     0);
    check("arst_used",   used_cnt_o,   0);
    check("arst_cyc",    nextrrfcyc_o, 0);
    drive(0, 0, 0, 2'd0, 0);
    tick();
    reset_n_i = 1'b1;

    // Flush: build rrfptr=20, comptr=12
    drive(1, 1, 1, 2'd0, 0);
    for (int i = 0; i < 10; i++) tick();
    drive(0, 0, 0, 2'd2, 0);
    for (int i = 0; i < 6; i++) tick();
    check("pf_ptr",    rrfptr_o,   20);
    check("pf_comptr", comptr_o,   12);
    check("pf_used",   used_cnt_o, 8);
    drive(1, 1, 1, 2'd1, 1);
    check("flush_fire", alloc_fire_o, 0);
    tick();
    drive(0, 0, 0, 2'd0, 0);
    check("flush_ptr",    rrfptr_o,      13);
    check("flush_comptr", comptr_o,      13);
    check("flush_used",   used_cnt_o,    0);
    check("flush_cyc",    nextrrfcyc_o,  0);
    check("flush_alloc",  allocatable_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
Allocation controller for the rename register file (RRF) entries that the rename table points at.
- Hands out up to two free rrftags per cycle to dispatch, in circular order.
- Reclaims up to two entries per cycle as the ROB commits.
- Discards all speculative allocations on a branch mispredict.
- Drives the dispatch-side stall and supplies the rrftags written into the rename table via dst_rrftag_setbusy.

Parameters:
- RRF_SEL, 6, rrftag width.
- RRF_NUM, 64, number of RRF entries; must equal 2**RRF_SEL.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req1_i  in  1  dispatch slot 1 needs a destination rrftag.
- req2_i  in  1  dispatch slot 2 needs a destination rrftag.
- dp_valid_i  in  1  dispatch group is valid this cycle.
- allocatable_o  out  1  enough free entries for the current request count.
- alloc_fire_o  out  1  allocation performed this cycle.
- rrftag1_o  out  RRF_SEL  tag granted to slot 1.
- rrftag2_o  out  RRF_SEL  tag granted to slot 2.
- rrfptr_o  out  RRF_SEL  next tag to allocate.
- nextrrfcyc_o  out  1  wrap-parity bit of rrfptr, used for age compare.
- com_num_i  in  2  entries retired by the ROB this cycle, 0..2.
- comptr_o  out  RRF_SEL  oldest uncommitted tag.
- prmiss_i  in  1  mispredict flush.
- used_cnt_o  out  RRF_SEL+1  entries currently allocated, 0..RRF_NUM.

Behaviour:
- Reset: an asynchronous assert of reset_n_i clears rrfptr, comptr, nextrrfcyc, comcyc (internal) and used_cnt to 0. Reset mid-operation drops all state immediately; no partial commit is applied.
- Allocation count: nreq = req1_i + req2_i (0..2).
- allocatable_o is combinational: (RRF_NUM - used_cnt) >= nreq.
  - Same-cycle frees are not credited, so the stall is conservative.
  - After reset it reads 1.
- alloc_fire_o is combinational: dp_valid_i & allocatable_o & ~prmiss_i & (nreq != 0).
- Tag outputs are combinational from rrfptr:
  - rrftag1_o = rrfptr.
  - rrftag2_o = req1_i ? rrfptr+1 : rrfptr.
  - Arithmetic is mod RRF_NUM.
  - Both tags are valid only when alloc_fire_o is 1.
- On alloc_fire_o at a clock edge:
  - rrfptr <= rrfptr + nreq, mod RRF_NUM.
  - nextrrfcyc toggles if rrfptr + nreq >= RRF_NUM (wrap past 63 to 0/1).
- Commit at each edge with com_num_i = k:
  - comptr <= comptr + k, mod RRF_NUM.
  - comcyc toggles on wrap.
  - k > used_cnt is illegal; the bench asserts on it, and the RTL saturates used_cnt at 0.
- used_cnt update at each edge, no flush: used_cnt <= used_cnt + (alloc_fire_o ? nreq : 0) - com_num_i. Allocation and commit in the same cycle both apply.
- Flush (prmiss_i = 1), which has priority over allocation:
  - This cycle's commits still apply.
  - rrfptr <= comptr + com_num_i.
  - nextrrfcyc <= comcyc, toggled if that commit wraps.
  - used_cnt <= 0.
  - No allocation occurs.
- Full: used_cnt == 64 gives allocatable_o = 0 for any nreq > 0. With used_cnt == 63, a single request is granted and a dual request stalls; there is no partial grant.
- Empty: used_cnt == 0 exactly when rrfptr == comptr and nextrrfcyc == comcyc.
- Latency: the grant is visible in the same cycle as the request. Pointer and count updates are visible on the next cycle.

Test Plan:
- Reset then dp_valid_i=1, req1_i=req2_i=1 -> rrftag1_o=0, rrftag2_o=1, alloc_fire_o=1; next cycle rrfptr_o=2, used_cnt_o=2.
- req1_i=0, req2_i=1 at rrfptr=5 -> rrftag2_o=5; next cycle rrfptr_o=6.
- Fill to used_cnt=63 with no commits; dual request -> allocatable_o=0, no state change. Single request -> granted, used_cnt_o=64. Any further request -> stall.
- Wrap: rrfptr=63, dual request -> tags 63 and 0; next cycle rrfptr_o=1 and nextrrfcyc_o toggled.
- Simultaneous dual allocation and com_num_i=2 at used_cnt=10 -> used_cnt_o stays 10; rrfptr and comptr both advance by 2.
- Flush with rrfptr=20, comptr=12, com_num_i=1, dual request -> no grant; next cycle rrfptr_o=13, comptr_o=13, used_cnt_o=0, nextrrfcyc_o equals comcyc. Async reset asserted mid-burst -> all outputs return to reset values before the next clock edge.
